qrd_output_deskew: RTL and testbench
====================================

// Module: qrd_output_deskew
// PURPOSE
//  Output-side counterpart of the QRD-RLS input skew stage: re-aligns the column-skewed
//  results (wxout1..3, error) leaving the systolic array into one time-aligned word per sample.
//  Buffers aligned words in a small FIFO and presents them downstream with valid/ready.
//  Sits between the array wrapper outputs and any consumer (logger, DMA, host interface).
// PARAMETERS
//  DATA_LENGTH  8   width of each result lane (error, wxout1..3)
//  FIFO_DEPTH   4   aligned-word buffer entries; power of two, >=2
//  CNT_WIDTH    16  width of sample_count
// PORTS
//  clk           in   1            system clock, all logic on posedge
//  rst           in   1            synchronous, active-high reset
//  in_valid      in   1            asserted in cycle wxout1_in carries a new sample
//  wxout1_in     in   DATA_LENGTH  weight 1, arrives at cycle c
//  wxout2_in     in   DATA_LENGTH  weight 2 of same sample, arrives at c+1
//  wxout3_in     in   DATA_LENGTH  weight 3 of same sample, arrives at c+2
//  error_in      in   DATA_LENGTH  error of same sample, arrives at c+3
//  out_ready     in   1            consumer accepts word when out_valid&&out_ready
//  out_valid     out  1            FIFO head holds an aligned word
//  wx1_out       out  DATA_LENGTH  aligned weight 1 (FIFO head)
//  wx2_out       out  DATA_LENGTH  aligned weight 2
//  wx3_out       out  DATA_LENGTH  aligned weight 3
//  error_out     out  DATA_LENGTH  aligned error
//  fifo_count    out  $clog2(FIFO_DEPTH)+1  current occupancy
//  overflow      out  1            sticky: an aligned word was dropped
//  sample_count  out  CNT_WIDTH    number of words handed off (out_valid&&out_ready)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): delay lines, valid pipe, FIFO pointers cleared; out_valid=0,
//    all data outputs 0, fifo_count=0, overflow=0, sample_count=0. Mid-operation reset
//    discards all in-flight and buffered samples; nothing emerges afterwards from them.
//  - Deskew: wxout1_in delayed 3 regs, wxout2_in 2, wxout3_in 1, error_in 0; in_valid
//    delayed 3 regs (push). Aligned word formed combinationally in cycle c+3, written at the
//    posedge closing c+3.
//  - Latency: in_valid at c, FIFO empty -> out_valid=1 in cycle c+4 with that sample.
//  - Back-to-back in_valid every cycle sustained; throughput 1 word/cycle while out_ready=1.
//  - FIFO: first-word-fall-through; data outputs show head entry, 0 when empty.
//    pop = out_valid&&out_ready; push = delayed valid.
//    * push, not full: write, count+1.  * pop, not empty: read, count-1.
//    * push&pop same cycle (any level incl. full): both occur, count unchanged.
//    * push when full without pop: word dropped, overflow<=1, held until rst.
//    * out_ready with FIFO empty: no effect.
//  - Pointers wrap modulo FIFO_DEPTH; count distinguishes full/empty.
//  - sample_count increments on each pop, wraps at 2^CNT_WIDTH-1 -> 0.
//  - Lane arithmetic: none; values pass bit-exact, unsigned/signed-agnostic.
// STRUCTURE
//  - Shared package qrd_pkg: DATA_LENGTH default, lane skew constants
//    (SKEW_W1=3, SKEW_W2=2, SKEW_W3=1, SKEW_ERR=0) shared with the input skew stage.
//  - One sub-module: qrd_sync_fifo (width 4*DATA_LENGTH, depth FIFO_DEPTH, FWFT,
//    count/full/empty); delay lines and counters stay in this module.
// TESTING
//  1 Single sample: in_valid@c, w1=0x11@c, w2=0x22@c+1, w3=0x33@c+2, err=0x44@c+3,
//    out_ready=1 -> out_valid=1 at c+4 with {0x11,0x22,0x33,0x44}, sample_count=1.
//  2 Streaming: 8 consecutive samples (w1=k, w2=k+0x10, w3=k+0x20, err=k+0x30),
//    out_ready=1 -> 8 consecutive aligned words in order, fifo_count<=1, overflow=0.
//  3 Backpressure: out_ready=0, 6 samples -> fifo_count saturates 4, overflow=1, samples
//    5-6 lost; then out_ready=1 -> exactly samples 1-4 emerge, sample_count=4.
//  4 Full with simultaneous push/pop: fill to 4, then out_ready=1 while streaming ->
//    count stays 4, no drop, overflow stays 0.
//  5 Reset mid-flight: 2 samples in delay lines + 2 in FIFO, rst one cycle -> next cycle
//    out_valid=0, all outputs 0, no stale words ever emitted.
//  6 Counter wrap: CNT_WIDTH=4, 17 handoffs -> sample_count reads 1.

Source files
------------

// File: rtl/qrd_pkg.sv
// rtl/qrd_pkg.sv - QRD-RLS shared constants: default lane width and per-lane column skew
package qrd_pkg;

    localparam int DEFAULT_DATA_LENGTH = 8;

    // Column skew of each result lane leaving the systolic array (shared with the input skew stage)
    localparam int SKEW_W1  = 3;
    localparam int SKEW_W2  = 2;
    localparam int SKEW_W3  = 1;
    localparam int SKEW_ERR = 0;

    localparam int LANES = 4;

endpackage

// File: rtl/qrd_sync_fifo.sv
// rtl/qrd_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module qrd_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot being written, even when full
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qrd_output_deskew.sv
// rtl/qrd_output_deskew.sv - re-aligns column-skewed QRD array results into buffered words
module qrd_output_deskew
    import qrd_pkg::*;
#(
    parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_LENGTH-1:0]        wxout1_in,
    input  logic [DATA_LENGTH-1:0]        wxout2_in,
    input  logic [DATA_LENGTH-1:0]        wxout3_in,
    input  logic [DATA_LENGTH-1:0]        error_in,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_LENGTH-1:0]        wx1_out,
    output logic [DATA_LENGTH-1:0]        wx2_out,
    output logic [DATA_LENGTH-1:0]        wx3_out,
    output logic [DATA_LENGTH-1:0]        error_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          sample_count
);

    localparam int WORD_W = LANES * DATA_LENGTH;

    logic [DATA_LENGTH-1:0] w1_pipe [SKEW_W1];
    logic [DATA_LENGTH-1:0] w2_pipe [SKEW_W2];
    logic [DATA_LENGTH-1:0] w3_pipe [SKEW_W3];
    logic [SKEW_W1-1:0]     valid_pipe;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] aligned_word;
    logic [WORD_W-1:0] head_word;

    // The valid bit travels with weight 1, the earliest lane of each sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKEW_W1; i++) w1_pipe[i] <= '0;
            for (int i = 0; i < SKEW_W2; i++) w2_pipe[i] <= '0;
            for (int i = 0; i < SKEW_W3; i++) w3_pipe[i] <= '0;
            valid_pipe <= '0;
        end else begin
            w1_pipe[0] <= wxout1_in;
            w2_pipe[0] <= wxout2_in;
            w3_pipe[0] <= wxout3_in;
            for (int i = 1; i < SKEW_W1; i++) w1_pipe[i] <= w1_pipe[i-1];
            for (int i = 1; i < SKEW_W2; i++) w2_pipe[i] <= w2_pipe[i-1];
            for (int i = 1; i < SKEW_W3; i++) w3_pipe[i] <= w3_pipe[i-1];
            valid_pipe <= {valid_pipe[SKEW_W1-2:0], in_valid};
        end
    end

    assign push         = valid_pipe[SKEW_W1-1];
    assign aligned_word = {w1_pipe[SKEW_W1-1], w2_pipe[SKEW_W2-1], w3_pipe[SKEW_W3-1], error_in};
    assign out_valid    = !fifo_empty;
    assign pop          = out_valid && out_ready;

    qrd_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (aligned_word),
        .pop       (pop),
        .pop_data  (head_word),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {wx1_out, wx2_out, wx3_out, error_out} = head_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow     <= 1'b0;
            sample_count <= '0;
        end else begin
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                sample_count <= sample_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qrd_output_deskew.sv
// tb/tb_qrd_output_deskew.sv - randomized and directed bench for qrd_output_deskew
module tb_qrd_output_deskew;

    localparam int DL    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int N     = 700;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DL-1:0] wxout1_in, wxout2_in, wxout3_in, error_in;
    logic          out_ready;
    logic          out_valid;
    logic [DL-1:0] wx1_out, wx2_out, wx3_out, error_out;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic [CW-1:0] sample_count;

    always #5 clk = ~clk;

    qrd_output_deskew #(
        .DATA_LENGTH (DL),
        .FIFO_DEPTH  (DEPTH),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .wxout1_in    (wxout1_in),
        .wxout2_in    (wxout2_in),
        .wxout3_in    (wxout3_in),
        .error_in     (error_in),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .wx1_out      (wx1_out),
        .wx2_out      (wx2_out),
        .wx3_out      (wx3_out),
        .error_out    (error_out),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .sample_count (sample_count)
    );

    bit            p_valid [N+8];
    bit            p_ready [N+8];
    bit            p_rst   [N+8];
    logic [DL-1:0] p_w1    [N+8];
    logic [DL-1:0] p_w2    [N+8];
    logic [DL-1:0] p_w3    [N+8];
    logic [DL-1:0] p_err   [N+8];

    int n_checks = 0;
    int n_err    = 0;
    int cur_t    = 0;

    logic [31:0] mq [$];
    bit          m_ovf;
    int          m_sc;
    int          last_rst;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cur_t, obs, exp);
        end
    endtask

    task automatic send(input int c, input logic [DL-1:0] a, input logic [DL-1:0] b,
                        input logic [DL-1:0] cc, input logic [DL-1:0] d);
        p_valid[c]   = 1'b1;
        p_w1[c]      = a;
        p_w2[c+1]    = b;
        p_w3[c+2]    = cc;
        p_err[c+3]   = d;
    endtask

    task automatic set_ready(input int lo, input int hi, input bit v);
        for (int i = lo; i <= hi; i++) p_ready[i] = v;
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] exp_word;
        bit          do_pop;
        bit          do_push;
        int          pr;

        for (int i = 0; i < N + 8; i++) begin
            p_valid[i] = 1'b0;
            p_ready[i] = 1'b1;
            p_rst[i]   = 1'b0;
            p_w1[i]    = DL'($urandom);
            p_w2[i]    = DL'($urandom);
            p_w3[i]    = DL'($urandom);
            p_err[i]   = DL'($urandom);
        end
        for (int i = 0; i < 3; i++) p_rst[i] = 1'b1;

        send(5, 8'h11, 8'h22, 8'h33, 8'h44);
        for (int k = 1; k <= 8; k++)
            send(19 + k, DL'(k), DL'(k + 'h10), DL'(k + 'h20), DL'(k + 'h30));

        set_ready(40, 69, 1'b0);
        for (int i = 0; i < 6; i++)
            send(45 + i, DL'('h41 + i), DL'('h51 + i), DL'('h61 + i), DL'('h71 + i));
        p_rst[90] = 1'b1;

        set_ready(95, 106, 1'b0);
        for (int i = 0; i < 15; i++)
            send(100 + i, DL'('h60 + i), DL'('h70 + i), DL'('h80 + i), DL'('h90 + i));

        set_ready(135, 159, 1'b0);
        send(145, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
        send(146, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
        send(149, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
        send(150, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
        p_rst[151] = 1'b1;

        for (int i = 0; i < 17; i++)
            send(185 + i, DL'(i), DL'(i + 1), DL'(i + 2), DL'(i + 3));

        for (int t = 220; t < N; t++) begin
            case ((t / 40) % 3)
                0:       pr = 20;
                1:       pr = 60;
                default: pr = 100;
            endcase
            p_ready[t] = ($urandom_range(0, 99) < pr);
            p_valid[t] = (t < N - 4) && ($urandom_range(0, 1) == 1);
            p_rst[t]   = ($urandom_range(0, 149) == 0);
        end

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        wxout1_in = '0; wxout2_in = '0; wxout3_in = '0; error_in = '0;
        repeat (2) @(posedge clk);
        #1;

        m_ovf = 1'b0; m_sc = 0; last_rst = -1;

        for (int t = 0; t < N; t++) begin
            cur_t     = t;
            rst       = p_rst[t];
            in_valid  = p_valid[t];
            wxout1_in = p_w1[t];
            wxout2_in = p_w2[t];
            wxout3_in = p_w3[t];
            error_in  = p_err[t];
            out_ready = p_ready[t];

            @(negedge clk);
            word     = {wx1_out, wx2_out, wx3_out, error_out};
            exp_word = (mq.size() != 0) ? mq[0] : 32'h0;
            check("out_valid",    64'(out_valid),    64'(mq.size() != 0));
            check("word",         64'(word),         64'(exp_word));
            check("fifo_count",   64'(fifo_count),   64'(mq.size()));
            check("overflow",     64'(overflow),     64'(m_ovf));
            check("sample_count", 64'(sample_count), 64'(m_sc));

            case (t)
                9:   begin check("t1_valid", 64'(out_valid), 64'd1);
                           check("t1_word", 64'(word), 64'h11223344); end
                10:  check("t1_count", 64'(sample_count), 64'd1);
                24:  check("t2_first", 64'(word), 64'h01112131);
                31:  check("t2_last", 64'(word), 64'h08182838);
                32:  begin check("t2_drained", 64'(out_valid), 64'd0);
                           check("t2_count", 64'(sample_count), 64'd9); end
                60:  begin check("t3_full", 64'(fifo_count), 64'd4);
                           check("t3_ovf", 64'(overflow), 64'd1); end
                70:  check("t3_head", 64'(word), 64'h41516171);
                80:  begin check("t3_count", 64'(sample_count), 64'd13);
                           check("t3_drained", 64'(out_valid), 64'd0); end
                91:  check("rst_ovf", 64'(overflow), 64'd0);
                112: begin check("t4_full", 64'(fifo_count), 64'd4);
                           check("t4_ovf", 64'(overflow), 64'd0); end
                130: check("t4_count", 64'(sample_count), 64'd15);
                150: check("t5_pre", 64'(fifo_count), 64'd2);
                152: begin check("t5_valid", 64'(out_valid), 64'd0);
                           check("t5_word", 64'(word), 64'd0);
                           check("t5_fcount", 64'(fifo_count), 64'd0); end
                215: check("t6_wrap", 64'(sample_count), 64'd1);
                default: ;
            endcase

            @(posedge clk);
            if (p_rst[t]) begin
                mq.delete();
                m_ovf    = 1'b0;
                m_sc     = 0;
                last_rst = t;
            end else begin
                do_pop  = (mq.size() != 0) && p_ready[t];
                do_push = (t >= 3) && p_valid[t-3] && ((t - 3) > last_rst);
                if (do_pop) begin
                    void'(mq.pop_front());
                    m_sc = (m_sc + 1) % (1 << CW);
                end
                if (do_push) begin
                    if (mq.size() < DEPTH)
                        mq.push_back({p_w1[t-3], p_w2[t-2], p_w3[t-1], p_err[t]});
                    else
                        m_ovf = 1'b1;
                end
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
